// File: rtl/game_sequencer.sv
// game_sequencer: round controller for the whack-a-switch game.
// Picks a pseudo-random one-hot target, times target lifetime and the
// inter-target gap, and runs the overall game countdown.
// Optional feature macro: GAME_SEQUENCER_SPEEDUP_EN (every 5th hit shortens
// the target lifetime by 1/8, floored at TARGET_MS/4).
module game_sequencer #(
    parameter int unsigned N_SW      = 18,
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned GAME_SEC  = 30,
    parameter int unsigned TARGET_MS = 1000,
    parameter int unsigned GAP_MS    = 200,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            target_hit,
    output logic [N_SW-1:0] curr_target,
    output logic            game_over,
    output logic [7:0]      time_left,
    output logic            target_timeout,
    output logic            busy
);

    localparam int unsigned TICK_DIV = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
    localparam int unsigned PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned MS_W     = 16;
    localparam int unsigned SEC_W    = 10;
    localparam int unsigned IDX_W    = (N_SW > 1) ? $clog2(N_SW) : 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SPAWN    = 3'd1,
        S_WAIT_HIT = 3'd2,
        S_GAP      = 3'd3,
        S_OVER     = 3'd4
    } state_t;

    state_t state;
    state_t next_state;

    logic [15:0]      lfsr;
    logic [PRE_W-1:0] presc;
    logic [SEC_W-1:0] sec_cnt;
    logic [MS_W-1:0]  ms_cnt;
    logic [IDX_W-1:0] prev_idx;
    logic [MS_W-1:0]  lifetime;

    logic             in_busy;
    logic             game_start;
    logic             ms_tick;
    logic             sec_wrap;
    logic             expire;
    logic             tmo;
    logic             gap_done;
    logic             hit_ok;
    logic [IDX_W-1:0] idx_raw;
    logic [IDX_W-1:0] idx_sel;
    logic [N_SW-1:0]  spawn_onehot;

    logic [N_SW-1:0]  curr_target_d;
    logic             game_over_d;
    logic [7:0]       time_left_d;
    logic             timeout_d;
    logic             busy_d;

    // Shared timing and event decode
    assign in_busy    = (state == S_SPAWN) || (state == S_WAIT_HIT) || (state == S_GAP);
    assign game_start = start && ((state == S_IDLE) || (state == S_OVER));
    assign ms_tick    = in_busy && (presc == PRE_W'(TICK_DIV - 1));
    assign sec_wrap   = ms_tick && (sec_cnt == SEC_W'(999));
    assign expire     = sec_wrap && (time_left == 8'd1);
    assign tmo        = ms_tick && (ms_cnt == lifetime - MS_W'(1));
    assign gap_done   = ms_tick && (ms_cnt == MS_W'(GAP_MS - 1));
    assign hit_ok     = (state == S_WAIT_HIT) && target_hit && !expire;

    // Target index selection: LFSR mod N_SW, bumped to avoid repeating the last target
    always_comb begin
        idx_raw = IDX_W'(lfsr % 16'(N_SW));
        idx_sel = idx_raw;
        if (idx_raw == prev_idx) begin
            idx_sel = (idx_raw == IDX_W'(N_SW - 1)) ? '0 : idx_raw + IDX_W'(1);
        end
        spawn_onehot = N_SW'(1) << idx_sel;
    end

`ifdef GAME_SEQUENCER_SPEEDUP_EN
    localparam int unsigned LIFE_MIN = TARGET_MS / 4;

    logic [5:0]      hit_cnt;
    logic [5:0]      hit_cnt_inc;
    logic [MS_W-1:0] life_cut;

    assign hit_cnt_inc = hit_cnt + 6'd1;

    // Shortened lifetime candidate, floored at a quarter of the base lifetime
    always_comb begin
        life_cut = lifetime - (lifetime >> 3);
        if (life_cut < MS_W'(LIFE_MIN)) begin
            life_cut = MS_W'(LIFE_MIN);
        end
    end

    // Hit counter and lifetime register, restored at each game start
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            lifetime <= MS_W'(TARGET_MS);
        end else if (game_start) begin
            hit_cnt  <= '0;
            lifetime <= MS_W'(TARGET_MS);
        end else if (hit_ok) begin
            hit_cnt <= hit_cnt_inc;
            if ((hit_cnt_inc % 6'd5) == 6'd0) begin
                lifetime <= life_cut;
            end
        end
    end
`else
    assign lifetime = MS_W'(TARGET_MS);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; expiry outranks hit, timeout and spawn
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_OVER: begin
                if (start) next_state = S_SPAWN;
            end
            S_SPAWN: begin
                next_state = expire ? S_OVER : S_WAIT_HIT;
            end
            S_WAIT_HIT: begin
                if (expire)                 next_state = S_OVER;
                else if (target_hit || tmo) next_state = S_GAP;
            end
            S_GAP: begin
                if (expire)        next_state = S_OVER;
                else if (gap_done) next_state = S_SPAWN;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Output next values, derived from the state transition
    always_comb begin
        curr_target_d = '0;
        timeout_d     = 1'b0;
        game_over_d   = (next_state == S_OVER);
        busy_d        = (next_state == S_SPAWN) || (next_state == S_WAIT_HIT) ||
                        (next_state == S_GAP);
        time_left_d   = time_left;
        if (next_state == S_WAIT_HIT) begin
            curr_target_d = (state == S_SPAWN) ? spawn_onehot : curr_target;
        end
        if ((state == S_WAIT_HIT) && (next_state == S_GAP) && !target_hit) begin
            timeout_d = 1'b1;
        end
        if (game_start) begin
            time_left_d = 8'(GAME_SEC);
        end else if (sec_wrap) begin
            time_left_d = time_left - 8'd1;
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            curr_target    <= '0;
            game_over      <= 1'b0;
            time_left      <= 8'(GAME_SEC);
            target_timeout <= 1'b0;
            busy           <= 1'b0;
        end else begin
            curr_target    <= curr_target_d;
            game_over      <= game_over_d;
            time_left      <= time_left_d;
            target_timeout <= timeout_d;
            busy           <= busy_d;
        end
    end

    // Free-running LFSR, ms prescaler, second counter, phase counter, last index
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr     <= LFSR_SEED;
            presc    <= '0;
            sec_cnt  <= '0;
            ms_cnt   <= '0;
            prev_idx <= '0;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

            if (game_start) begin
                presc <= '0;
            end else if (in_busy) begin
                presc <= (presc == PRE_W'(TICK_DIV - 1)) ? '0 : presc + PRE_W'(1);
            end

            if (game_start) begin
                sec_cnt <= '0;
            end else if (ms_tick) begin
                sec_cnt <= (sec_cnt == SEC_W'(999)) ? '0 : sec_cnt + SEC_W'(1);
            end

            if (state != next_state) begin
                ms_cnt <= '0;
            end else if (ms_tick) begin
                ms_cnt <= ms_cnt + MS_W'(1);
            end

            if ((state == S_SPAWN) && (next_state == S_WAIT_HIT)) begin
                prev_idx <= idx_sel;
            end
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with 1 ms = 1 cycle, 3 s game,
// 50 ms target lifetime and 10 ms gap.
module tb_game_sequencer;

    localparam int unsigned N = 18;

    logic         clk;
    logic         rst;
    logic         start;
    logic         target_hit;
    logic [N-1:0] curr_target;
    logic         game_over;
    logic [7:0]   time_left;
    logic         target_timeout;
    logic         busy;

    int           n_checks;
    int           n_errors;
    int           cyc;
    int           m_prev;
    logic [15:0]  m_lfsr;
    logic [N-1:0] exp_tgt;
    logic [N-1:0] old_tgt;

    game_sequencer #(
        .N_SW      (N),
        .CLK_HZ    (1000),
        .GAME_SEC  (3),
        .TARGET_MS (50),
        .GAP_MS    (10),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .target_hit     (target_hit),
        .curr_target    (curr_target),
        .game_over      (game_over),
        .time_left      (time_left),
        .target_timeout (target_timeout),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR, taps 16,14,13,11
    always @(posedge clk) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    // Pulse start; afterwards cyc counts edges since the start edge
    task automatic start_game();
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
    endtask

    // Called during the SPAWN cycle: predicts the target lit on the next edge
    task automatic spawn_expect();
        int idx;
        idx = int'(m_lfsr % 16'd18);
        if (idx == m_prev) idx = (idx + 1) % 18;
        m_prev  = idx;
        exp_tgt = N'(1) << idx;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_tgt"},  curr_target, 0);
        check_eq({tag, "_go"},   game_over, 0);
        check_eq({tag, "_tl"},   time_left, 3);
        check_eq({tag, "_tmo"},  target_timeout, 0);
        check_eq({tag, "_busy"}, busy, 0);
    endtask

`ifdef GAME_SEQUENCER_SPEEDUP_EN
    task automatic wait_lit(input string tag);
        int n;
        n = 0;
        while (curr_target == '0 && n < 100) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(curr_target != '0), 1);
    endtask

    task automatic hit_five();
        for (int i = 0; i < 5; i++) begin
            target_hit = 1'b1;
            tick();
            target_hit = 1'b0;
            wait_lit("sp_relit");
        end
    endtask

    task automatic measure_life(input string tag, input int exp);
        int n;
        n = 0;
        while (target_timeout !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check_eq(tag, n, exp);
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; target_hit = 1'b0;
        n_checks = 0; n_errors = 0; cyc = 0; m_prev = 0;
        exp_tgt = '0; old_tgt = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_vals("rst");

        // Game 1: spawn, hit, timeout, hit/timeout collision, busy start, expiry in GAP
        start_game();
        check_eq("t1_busy", busy, 1);
        check_eq("t1_tgt_spawn", curr_target, 0);
        spawn_expect();
        tick();
        check_eq("t1_tgt", curr_target, exp_tgt);
        check_eq("t1_tl", time_left, 3);
        check_eq("t1_go", game_over, 0);
        old_tgt = exp_tgt;

        run_to(5);
        target_hit = 1'b1;
        tick();
        target_hit = 1'b0;
        check_eq("t2_cleared", curr_target, 0);
        check_eq("t2_no_tmo", target_timeout, 0);
        run_to(16);
        check_eq("t2_gap_tgt", curr_target, 0);
        check_eq("t2_gap_busy", busy, 1);
        spawn_expect();
        tick();
        check_eq("t2_new_tgt", curr_target, exp_tgt);
        check_eq("t2_differs", 32'(curr_target != old_tgt), 1);

        run_to(66);
        check_eq("t3_still_lit", curr_target, exp_tgt);
        check_eq("t3_tmo_early", target_timeout, 0);
        tick();
        check_eq("t3_tmo", target_timeout, 1);
        check_eq("t3_tgt_clr", curr_target, 0);
        tick();
        check_eq("t3_tmo_1cyc", target_timeout, 0);
        run_to(77);
        spawn_expect();
        tick();
        check_eq("t3_relit", curr_target, exp_tgt);

        run_to(127);
        target_hit = 1'b1;
        tick();
        target_hit = 1'b0;
        check_eq("t5_hit_wins_tmo", target_timeout, 0);
        check_eq("t5_hit_wins_tgt", curr_target, 0);
        tick();
        check_eq("t5_no_late_tmo", target_timeout, 0);
        run_to(138);
        spawn_expect();
        tick();
        check_eq("t5_relit", curr_target, exp_tgt);

        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("t6_busy_start_tgt", curr_target, exp_tgt);
        check_eq("t6_busy_start_busy", busy, 1);

        run_to(999);
        check_eq("t4_tl_999", time_left, 3);
        tick();
        check_eq("t4_tl_1000", time_left, 2);
        run_to(1999);
        check_eq("t4_tl_1999", time_left, 2);
        tick();
        check_eq("t4_tl_2000", time_left, 1);
        run_to(2999);
        check_eq("t4_tl_2999", time_left, 1);
        check_eq("t4_go_2999", game_over, 0);
        tick();
        check_eq("t4_tl_3000", time_left, 0);
        check_eq("t4_go_3000", game_over, 1);
        check_eq("t4_tgt_3000", curr_target, 0);
        check_eq("t4_busy_3000", busy, 0);

        target_hit = 1'b1;
        tick();
        target_hit = 1'b0;
        tick();
        check_eq("t4_over_go", game_over, 1);
        check_eq("t4_over_busy", busy, 0);
        check_eq("t4_over_tgt", curr_target, 0);
        check_eq("t4_over_tl", time_left, 0);

        // Game 2: restart from OVER, then reset mid WAIT_HIT
        start_game();
        check_eq("t4_restart_tl", time_left, 3);
        check_eq("t4_restart_go", game_over, 0);
        check_eq("t4_restart_busy", busy, 1);
        tick();
        check_eq("t4_restart_onehot", $countones(curr_target), 1);
        run_to(5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_vals("t6_rst");
        m_prev = 0;

        // Game 3: no hits, then a hit landing on the expiry cycle
        start_game();
        spawn_expect();
        tick();
        check_eq("g3_tgt", curr_target, exp_tgt);
        run_to(2999);
        check_eq("t5_exp_lit", $countones(curr_target), 1);
        target_hit = 1'b1;
        tick();
        target_hit = 1'b0;
        check_eq("t5_exp_go", game_over, 1);
        check_eq("t5_exp_busy", busy, 0);
        check_eq("t5_exp_tgt", curr_target, 0);
        check_eq("t5_exp_tmo", target_timeout, 0);
        check_eq("t5_exp_tl", time_left, 0);

`ifdef GAME_SEQUENCER_SPEEDUP_EN
        // Game 4: lifetime shrinks 50 -> 44 -> 39 on every 5th hit
        start_game();
        tick();
        wait_lit("sp_first");
        hit_five();
        measure_life("sp_life_44", 44);
        wait_lit("sp_after_tmo");
        hit_five();
        measure_life("sp_life_39", 39);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
